// File: rtl/if_fetch.sv
// Instruction fetch front end: keeps the instruction ROM streaming one word
// per cycle, buffers up to two fetched words for decode, and redirects on
// jump requests from execute without leaking stale instructions.
module if_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        jump_en_i,
   input  logic [31:0] jump_addr_i,
   output logic        rom_r_en_o,
   output logic [31:0] rom_r_addr_o,
   input  logic [31:0] rom_r_data_i,
   output logic        inst_valid_o,
   input  logic        inst_ready_i,
   output logic [31:0] inst_o,
   output logic [31:0] inst_addr_o
);

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic [31:0] pc;
   logic        inflight;
   logic [31:0] inflight_addr;
   logic [31:0] fifo_addr [2];
   logic [31:0] fifo_inst [2];
   logic        rd_ptr;
   logic        wr_ptr;
   logic [1:0]  occ;
   logic        push;
   logic        pop;
   logic        issue;
   logic [2:0]  pending;
   logic [31:0] head_addr;
   logic [31:0] head_inst;
   logic        unused_jump_lsbs;

   // Byte offset of a jump target is irrelevant: fetches are word aligned.
   assign unused_jump_lsbs = ^jump_addr_i[1:0];

   // Head of the buffer; when the buffer is empty the word returning from the
   // ROM this cycle is presented directly so a new stream costs one cycle.
   always_comb begin
      head_addr = inflight_addr;
      head_inst = rom_r_data_i;
      if (occ != 2'd0) begin
         head_addr = fifo_addr[rd_ptr];
         head_inst = fifo_inst[rd_ptr];
      end
   end

   assign inst_valid_o = ~rst & ~jump_en_i & ((occ != 2'd0) | inflight);
   assign inst_o       = inst_valid_o ? head_inst : NOP;
   assign inst_addr_o  = inst_valid_o ? head_addr : 32'h0000_0000;
   assign pop          = inst_valid_o & inst_ready_i;

   // Returning ROM data is kept unless a jump or reset makes it stale.
   assign push = ~rst & ~jump_en_i & inflight;

   // Words owed to decode after this cycle (buffered plus returning, minus
   // the one consumed now); never underflows because pop implies a word.
   assign pending = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
   assign issue   = ~rst & (jump_en_i | (pending < 3'd2));

   assign rom_r_en_o   = issue;
   assign rom_r_addr_o = jump_en_i ? {jump_addr_i[31:2], 2'b00} : pc;

   // Program counter, in-flight tracking and buffer bookkeeping.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc            <= RESET_PC;
         inflight      <= 1'b0;
         inflight_addr <= 32'h0000_0000;
         rd_ptr        <= 1'b0;
         wr_ptr        <= 1'b0;
         occ           <= 2'd0;
      end else begin
         inflight <= issue;
         if (issue) begin
            pc            <= rom_r_addr_o + 32'd4;
            inflight_addr <= rom_r_addr_o;
         end
         if (jump_en_i) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            occ    <= 2'd0;
         end else begin
            if (push) begin
               wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
               rd_ptr <= ~rd_ptr;
            end
            occ <= occ + {1'b0, push} - {1'b0, pop};
         end
      end
   end

   // Buffer storage; a word pushed and popped in the same cycle passes
   // through harmlessly because both pointers advance together.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_addr[wr_ptr] <= inflight_addr;
         fifo_inst[wr_ptr] <= rom_r_data_i;
      end
   end

endmodule
